// File: rtl/timer_periph_if.sv
// CPU-side control bus of the seconds timer: write strobe and duration in,
// sticky done / busy / remaining seconds back out through the read mux.
interface timer_periph_if;
  logic        ctrl_we;
  logic [31:0] ctrl_wdata;
  logic        done_clr;
  logic        done_rdata;
  logic        busy_rdata;
  logic [31:0] remain_rdata;

  modport master (
    output ctrl_we, ctrl_wdata, done_clr,
    input  done_rdata, busy_rdata, remain_rdata
  );

  modport slave (
    input  ctrl_we, ctrl_wdata, done_clr,
    output done_rdata, busy_rdata, remain_rdata
  );
endinterface

// File: rtl/timer_periph.sv
// Seconds countdown timer with sticky done flag; all outputs registered, one-edge write latency.
// No backpressure: a write is always accepted and restarts or aborts the count immediately.
module timer_periph #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int Simulacion = 0,
  parameter int TICKS_SIM  = 10
) (
  input  logic          clk,
  input  logic          reset,
  timer_periph_if.slave bus
);

  localparam int TICKS = (Simulacion != 0) ? TICKS_SIM : CLK_HZ;
  localparam int PW    = $clog2(TICKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [31:0]   remain_q;
  logic          done_q;
  logic          busy_q;
  logic [31:0]   remain_dec_d;

  assign remain_dec_d = remain_q - 32'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (bus.ctrl_we) begin
      // A write beats done_clr and the final tick; zero data is an abort.
      presc_q <= '0;
      done_q  <= 1'b0;
      if (bus.ctrl_wdata != 32'd0) begin
        state_q  <= ST_RUN;
        remain_q <= bus.ctrl_wdata;
        busy_q   <= 1'b1;
      end else begin
        state_q  <= ST_IDLE;
        remain_q <= '0;
        busy_q   <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (presc_q == PRESC_LAST) begin
            presc_q  <= '0;
            remain_q <= remain_dec_d;
            if (remain_q == 32'd1) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.done_clr) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done_rdata   = done_q;
  assign bus.busy_rdata   = busy_q;
  assign bus.remain_rdata = remain_q;

endmodule

// File: tb/tb_timer_periph.sv
// Bench for timer_periph with TICKS=10: table of timed checkpoints with fixed expected values,
// plus a per-cycle reference model whose predictions flow through a queue.
module tb_timer_periph;

  localparam int TICKS = 10;

  logic clk;
  logic reset;
  timer_periph_if bus ();

  timer_periph #(
    .CLK_HZ    (10_000_000),
    .Simulacion(1),
    .TICKS_SIM (TICKS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rstn;
    bit          we;
    logic [31:0] wdata;
    bit          clr;
    int          hold;
    bit          e_done;
    bit          e_busy;
    logic [31:0] e_rem;
  } vec_t;

  typedef struct {
    bit          done;
    bit          busy;
    logic [31:0] rem;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: 0 idle, 1 counting, 2 done.
  int          m_state = 0;
  int          m_presc = 0;
  logic [31:0] m_rem   = '0;

  task automatic add(input string n, input bit rstn, input bit we, input logic [31:0] wd,
                     input bit clr, input int hold, input bit ed, input bit eb,
                     input logic [31:0] er);
    vec_t v;
    v.name = n; v.rstn = rstn; v.we = we; v.wdata = wd; v.clr = clr;
    v.hold = hold; v.e_done = ed; v.e_busy = eb; v.e_rem = er;
    vecs.push_back(v);
  endtask

  task automatic model_step(input bit rstn, input bit we, input logic [31:0] wd, input bit clr);
    if (!rstn) begin
      m_state = 0; m_presc = 0; m_rem = '0;
    end else if (we) begin
      m_presc = 0;
      m_rem   = wd;
      m_state = (wd != 0) ? 1 : 0;
    end else if (m_state == 1) begin
      if (m_presc == TICKS - 1) begin
        m_presc = 0;
        m_rem   = m_rem - 1;
        if (m_rem == 0) m_state = 2;
      end else begin
        m_presc = m_presc + 1;
      end
    end else if (m_state == 2 && clr) begin
      m_state = 0;
    end
  endtask

  task automatic apply(input bit rstn, input bit we, input logic [31:0] wd, input bit clr,
                       input int hold);
    exp_t p;
    exp_t e;
    for (int i = 0; i < hold; i++) begin
      reset          = rstn;
      bus.ctrl_we    = we;
      bus.ctrl_wdata = wd;
      bus.done_clr   = clr;
      @(posedge clk);
      cyc++;
      model_step(rstn, we, wd, clr);
      p.done = (m_state == 2);
      p.busy = (m_state == 1);
      p.rem  = m_rem;
      sb_q.push_back(p);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (bus.done_rdata !== e.done || bus.busy_rdata !== e.busy || bus.remain_rdata !== e.rem) begin
        errors++;
        $display("FAIL sb cycle %0d: got done=%b busy=%b remain=%0d, expected done=%b busy=%b remain=%0d",
                 cyc, bus.done_rdata, bus.busy_rdata, bus.remain_rdata, e.done, e.busy, e.rem);
      end
    end
    reset          = 1'b1;
    bus.ctrl_we    = 1'b0;
    bus.ctrl_wdata = '0;
    bus.done_clr   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b0;
    bus.ctrl_we    = 1'b0;
    bus.ctrl_wdata = '0;
    bus.done_clr   = 1'b0;

    // name, rstn, we, wdata, clr, hold, exp done, busy, remain (sampled after the last held edge)
    add("rst_hold",  0, 1, 32'd5, 0,   3, 0, 0, 32'd0);
    add("rst_rel",   1, 0, 32'd0, 0,   1, 0, 0, 32'd0);
    add("n1_wr",     1, 1, 32'd1, 0,   1, 0, 1, 32'd1);
    add("n1_e9",     1, 0, 32'd0, 0,   9, 0, 1, 32'd1);
    add("n1_e10",    1, 0, 32'd0, 0,   1, 1, 0, 32'd0);
    add("n1_e14",    1, 0, 32'd0, 0,   4, 1, 0, 32'd0);
    add("n1_clr15",  1, 0, 32'd0, 1,   1, 0, 0, 32'd0);
    add("n5_wr",     1, 1, 32'd5, 0,   1, 0, 1, 32'd5);
    add("n5_e10",    1, 0, 32'd0, 0,  10, 0, 1, 32'd4);
    add("n5_e20",    1, 0, 32'd0, 0,  10, 0, 1, 32'd3);
    add("n5_e30",    1, 0, 32'd0, 0,  10, 0, 1, 32'd2);
    add("n5_e40",    1, 0, 32'd0, 0,  10, 0, 1, 32'd1);
    add("n5_e49",    1, 0, 32'd0, 0,   9, 0, 1, 32'd1);
    add("n5_e50",    1, 0, 32'd0, 0,   1, 1, 0, 32'd0);
    add("n5_sticky", 1, 0, 32'd0, 0, 100, 1, 0, 32'd0);
    add("rs_wr5",    1, 1, 32'd5, 0,   1, 0, 1, 32'd5);
    add("rs_e22",    1, 0, 32'd0, 0,  22, 0, 1, 32'd3);
    add("rs_wr2",    1, 1, 32'd2, 0,   1, 0, 1, 32'd2);
    add("rs_e42",    1, 0, 32'd0, 0,  19, 0, 1, 32'd1);
    add("rs_e43",    1, 0, 32'd0, 0,   1, 1, 0, 32'd0);
    add("rs_clr",    1, 0, 32'd0, 1,   1, 0, 0, 32'd0);
    add("ab_wr3",    1, 1, 32'd3, 0,   1, 0, 1, 32'd3);
    add("ab_e14",    1, 0, 32'd0, 0,  14, 0, 1, 32'd2);
    add("ab_abort",  1, 1, 32'd0, 0,   1, 0, 0, 32'd0);
    add("ab_quiet",  1, 0, 32'd0, 0, 100, 0, 0, 32'd0);
    add("fin_wr1",   1, 1, 32'd1, 0,   1, 0, 1, 32'd1);
    add("fin_e9",    1, 0, 32'd0, 0,   9, 0, 1, 32'd1);
    add("fin_wr2",   1, 1, 32'd2, 0,   1, 0, 1, 32'd2);
    add("fin_e29",   1, 0, 32'd0, 0,  19, 0, 1, 32'd1);
    add("fin_e30",   1, 0, 32'd0, 0,   1, 1, 0, 32'd0);
    add("we_clr",    1, 1, 32'd1, 1,   1, 0, 1, 32'd1);
    add("we_clr_e5", 1, 0, 32'd0, 0,   5, 0, 1, 32'd1);
    add("mid_rst",   0, 0, 32'd0, 0,   1, 0, 0, 32'd0);
    add("post_rst",  1, 0, 32'd0, 0,  20, 0, 0, 32'd0);
    add("clr_wr2",   1, 1, 32'd2, 0,   1, 0, 1, 32'd2);
    add("clr_run",   1, 0, 32'd0, 1,   5, 0, 1, 32'd2);
    add("clr_e20",   1, 0, 32'd0, 0,  15, 1, 0, 32'd0);
    add("max_wr",    1, 1, 32'hFFFF_FFFF, 0, 1, 0, 1, 32'hFFFF_FFFF);
    add("max_e10",   1, 0, 32'd0, 0,  10, 0, 1, 32'hFFFF_FFFE);
    add("max_abort", 1, 1, 32'd0, 0,   1, 0, 0, 32'd0);

    for (int v = 0; v < vecs.size(); v++) begin
      apply(vecs[v].rstn, vecs[v].we, vecs[v].wdata, vecs[v].clr, vecs[v].hold);
      checks++;
      if (bus.done_rdata !== vecs[v].e_done || bus.busy_rdata !== vecs[v].e_busy ||
          bus.remain_rdata !== vecs[v].e_rem) begin
        errors++;
        $display("FAIL %s: got done=%b busy=%b remain=%0d, expected done=%b busy=%b remain=%0d",
                 vecs[v].name, bus.done_rdata, bus.busy_rdata, bus.remain_rdata,
                 vecs[v].e_done, vecs[v].e_busy, vecs[v].e_rem);
      end
    end

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_periph.md
# timer_periph

Memory-mapped seconds timer that answers the CPU's timer control writes on the peripheral bus. The CPU writes a duration in seconds; the block counts it down from the processor clock (clk_10MHz in Top), then raises a sticky done flag that the CPU polls through the read mux. It is the peripheral-side counterpart of the TIMER_ctrl_we / TIMER_ctrl_wdata / TIMER_done_rdata signals in Top, and replaces the ad-hoc timer logic there.

## Interface

Parameters:
- CLK_HZ, 10_000_000: clock frequency; sets the number of ticks per second in hardware mode.
- Simulacion, 0: when 1, one "second" lasts TICKS_SIM cycles instead of CLK_HZ.
- TICKS_SIM, 10: cycles per second when Simulacion=1; must be ≥ 2.

Ports:
- clk, input, 1: processor clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low reset. The block is in reset while reset=0 at a rising edge.
- ctrl_we, input, 1: one-cycle write strobe to the control register.
- ctrl_wdata, input, 32: duration in seconds; 0 means abort.
- done_clr, input, 1: one-cycle acknowledge that clears done.
- done_rdata, output, 1: sticky completion flag.
- busy_rdata, output, 1: the timer is counting.
- remain_rdata, output, 32: seconds still to elapse, rounded up.

## Operation

- TICKS = Simulacion ? TICKS_SIM : CLK_HZ.
- Prescaler width is $clog2(TICKS). Seconds register is 32 bits, unsigned, and never wraps below 0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Reset (reset=0 at an edge): state=IDLE, prescaler=0, remain=0, done_rdata=0, busy_rdata=0. Reset overrides every other input, including in the middle of a count.
- ctrl_we=1 with ctrl_wdata=N≠0, in any state: go to RUN, set remain=N and prescaler=0, and clear done.
- ctrl_we=1 with ctrl_wdata=0, in any state: go to IDLE, set remain=0, clear done. This is the abort.
- In RUN, each cycle without ctrl_we:
  - If prescaler==TICKS-1, prescaler wraps to 0 and remain decrements. If remain was 1, the state goes to DONE and remain becomes 0.
  - Otherwise the prescaler increments.
- done_clr=1 while in DONE: go to IDLE. done_clr is ignored in IDLE and RUN.
- Simultaneous events:
  - ctrl_we together with done_clr: ctrl_we wins.
  - ctrl_we on the cycle of the final tick: ctrl_we wins, so done is not asserted and the count restarts with the new N.
- A write while in RUN restarts the count. It does not accumulate onto the remaining time.
- done stays at 1 until there is a write, a done_clr, or a reset.

## Timing

- All outputs are registered and change only on rising edges.
- A write sampled at edge k: busy_rdata=1 and remain_rdata=N are visible after edge k.
- remain_rdata decrements at edges k+TICKS, k+2·TICKS, and so on.
- done_rdata rises, and busy_rdata falls, at exactly edge k+N·TICKS.
- done_clr sampled at edge j: done_rdata=0 after edge j.
- Abort sampled at edge k: busy_rdata=0 and remain_rdata=0 after edge k.
- Maximum N = 2^32−1; no overflow handling is needed.

## Test plan

Setup for all scenarios: Simulacion=1, TICKS_SIM=10, edge index counted from the write.

1. Reset: hold reset=0 for 3 cycles with ctrl_we=1 and ctrl_wdata=5 → done_rdata=0, busy_rdata=0, remain_rdata=0 throughout. Release reset → values unchanged.
2. Write N=1 at edge 0:
   - busy=1 and remain=1 from edge 0.
   - done=1, busy=0, remain=0 at edge 10, and not before.
   - done_clr at edge 15 → done=0 and state IDLE after edge 15.
3. Write N=5 at edge 0:
   - remain reads 4, 3, 2, 1 after edges 10, 20, 30, 40.
   - done rises at edge 50.
   - done stays 1 for 100 further cycles with no clear.
4. Write N=5, then write N=2 at edge 23 → remain=2 after edge 23; done rises at edge 43, not at edge 50.
5. Write N=3, then abort (ctrl_wdata=0) at edge 15 → busy=0 and remain=0 after edge 15; done never rises within 100 cycles.
6. Simultaneous events:
   - Write N=1; at edge 10 assert ctrl_we with N=2 → done stays 0 and rises at edge 30.
   - Separately, in DONE, assert ctrl_we=1 (N=1) together with done_clr=1 → done=0 and busy=1 after that edge.
   - Separately, pull reset=0 mid-count → all outputs return to 0.
